if_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents the fetched instruction and PC+4 to the IF/ID pipeline register. It honours hazard-unit stalls and redirects on taken branches and jumps resolved in ID. While no instruction is available it emits a zero word (NOP).

---
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bundle between the fetch
// stage and instruction memory.
//   imem_req   - fetch request (fetch -> memory)
//   imem_addr  - fetch address (fetch -> memory)
//   imem_ack   - response for the address presented this cycle (memory -> fetch)
//   imem_rdata - instruction word, valid when imem_ack=1 (memory -> fetch)
// master: fetch-stage side; slave: memory side.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, fetches from instruction
// memory over a req/ack handshake and presents instruction + PC+4 to IF/ID.
// Emits a zero word (NOP) with Ins_valid=0 whenever no instruction is available.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   PC_write            - hazard-unit enable, 0 stalls fetch
//   branch_taken/target - taken branch resolved in ID
//   jump_taken/target   - jump resolved in ID (branch wins if both set)
//   imem (master)       - instruction memory handshake
//   Ins_out, PC_plus4   - instruction and fetch address + 4 (0 when invalid)
//   Ins_valid           - Ins_out/PC_plus4 carry a real instruction
//
// Optional feature: define FETCH_BUFFER_EN to add a HOLD state that captures
// the fetched word during a stall so memory is not re-read every stalled cycle.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    if_stage_if.master  imem,
    output logic [31:0] Ins_out,
    output logic [31:0] PC_plus4,
    output logic        Ins_valid
);

    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        redir;
    logic [31:0] redir_target;

    assign pc_inc       = pc + 32'd4;
    assign redir        = branch_taken | jump_taken;
    // Targets are always word aligned; low bits from ID are ignored.
    assign redir_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

`ifdef FETCH_BUFFER_EN
    typedef enum logic {StFetch, StHold} state_t;
    state_t      state;
    logic [31:0] hold_ins;
`endif

    // Outputs are gated by reset directly so the reset values appear in the
    // same cycle reset is asserted, before the synchronous update lands.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = RESET_PC;
        Ins_out        = 32'h0;
        PC_plus4       = 32'h0;
        Ins_valid      = 1'b0;
        if (!reset) begin
            imem.imem_addr = pc;
`ifdef FETCH_BUFFER_EN
            if (state == StHold) begin
                Ins_valid = 1'b1;
                Ins_out   = hold_ins;
                PC_plus4  = pc_inc;
            end else begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    Ins_valid = 1'b1;
                    Ins_out   = imem.imem_rdata;
                    PC_plus4  = pc_inc;
                end
            end
`else
            imem.imem_req = 1'b1;
            if (imem.imem_ack) begin
                Ins_valid = 1'b1;
                Ins_out   = imem.imem_rdata;
                PC_plus4  = pc_inc;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
`ifdef FETCH_BUFFER_EN
            state    <= StFetch;
            hold_ins <= 32'h0;
`endif
        end else if (redir) begin
            // Redirect beats a stall and drops any held word.
            pc       <= redir_target;
`ifdef FETCH_BUFFER_EN
            state    <= StFetch;
`endif
        end else if (Ins_valid && PC_write) begin
            pc       <= pc_inc;
`ifdef FETCH_BUFFER_EN
            state    <= StFetch;
`endif
        end
`ifdef FETCH_BUFFER_EN
        else if (state == StFetch && imem.imem_ack && !PC_write) begin
            hold_ins <= imem.imem_rdata;
            state    <= StHold;
        end
`endif
        // Without the buffer a stalled ack is discarded and the same address
        // is re-fetched next cycle.
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        PC_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic [31:0] Ins_out;
    logic [31:0] PC_plus4;
    logic        Ins_valid;
    logic [31:0] key = 32'hA5A5_0000;

    int total = 0;
    int bad   = 0;

    // Reference state: the address the stage should present, and whether an
    // instruction is being held across a stall (buffer build only).
    logic [31:0] m_pc;
    logic        m_held;
    logic [31:0] m_word;

    if_stage_if bus ();

    // Zero-latency memory: word at address a is a ^ key.
    assign bus.imem_rdata = bus.imem_addr ^ key;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .PC_write     (PC_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .imem         (bus.master),
        .Ins_out      (Ins_out),
        .PC_plus4     (PC_plus4),
        .Ins_valid    (Ins_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: drive inputs, compare outputs, advance one cycle.
    task automatic step(input logic r, input logic w, input logic bt_e, input logic [31:0] bt,
                        input logic jt_e, input logic [31:0] jt, input logic ack);
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_ins, e_p4;
        logic [31:0] n_pc;
        logic        n_held;
        logic [31:0] n_word;
        reset = r; PC_write = w; branch_taken = bt_e; branch_target = bt;
        jump_taken = jt_e; jump_target = jt; bus.imem_ack = ack;
        #1;
        if (r) begin
            e_req = 1'b0; e_addr = 32'h0; e_valid = 1'b0; e_ins = 32'h0; e_p4 = 32'h0;
        end else if (m_held) begin
            e_req = 1'b0; e_addr = m_pc; e_valid = 1'b1; e_ins = m_word; e_p4 = m_pc + 32'd4;
        end else begin
            e_req = 1'b1; e_addr = m_pc; e_valid = ack;
            e_ins = ack ? (m_pc ^ key) : 32'h0;
            e_p4  = ack ? (m_pc + 32'd4) : 32'h0;
        end
        check("imem_req",  {31'h0, bus.imem_req}, {31'h0, e_req});
        check("imem_addr", bus.imem_addr, e_addr);
        check("Ins_valid", {31'h0, Ins_valid}, {31'h0, e_valid});
        check("Ins_out",   Ins_out, e_ins);
        check("PC_plus4",  PC_plus4, e_p4);
        n_pc = m_pc; n_held = m_held; n_word = m_word;
        if (r) begin
            n_pc = 32'h0; n_held = 1'b0;
        end else if (bt_e || jt_e) begin
            n_pc = {(bt_e ? bt[31:2] : jt[31:2]), 2'b00}; n_held = 1'b0;
        end else if (e_valid && w) begin
            n_pc = m_pc + 32'd4; n_held = 1'b0;
        end else if (!m_held && ack && !w) begin
`ifdef FETCH_BUFFER_EN
            n_held = 1'b1; n_word = m_pc ^ key;
`endif
        end
        @(posedge clk);
        m_pc = n_pc; m_held = n_held; m_word = n_word;
        @(negedge clk);
    endtask

    initial begin
        m_pc = 32'h0; m_held = 1'b0; m_word = 32'h0;
        reset = 1'b1; PC_write = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump_taken = 1'b0; jump_target = 32'h0; bus.imem_ack = 1'b0;
        @(negedge clk);
        // Reset, then straight-line fetch 0,4
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        check("seq_addr4", bus.imem_addr, 32'h4);
        step(0, 1, 0, 0, 0, 0, 1);
        check("seq_addr8", bus.imem_addr, 32'h8);
        // Three-cycle stall at pc=8
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            check("stall_addr", bus.imem_addr, 32'h8);
            check("stall_ins", Ins_out, 32'hA5A5_0008);
        end
        step(0, 1, 0, 0, 0, 0, 1);
        check("resume_addr", bus.imem_addr, 32'hC);
        step(0, 1, 0, 0, 0, 0, 1);
        // Branch at pc=10 overrides stall, low bits dropped
        step(0, 0, 1, 32'h0000_0103, 0, 0, 1);
        check("branch_addr", bus.imem_addr, 32'h100);
        step(0, 1, 1, 32'h0000_0200, 1, 32'h0000_0300, 1);
        check("branch_prio", bus.imem_addr, 32'h200);
        step(0, 1, 0, 0, 1, 32'h0000_0020, 0);
        // Two wait states at pc=20
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("wait_addr", bus.imem_addr, 32'h20);
        step(0, 1, 0, 0, 0, 0, 1);
        check("after_wait", bus.imem_addr, 32'h24);
        // Wrap from FFFF_FFFC
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        check("jump_top", bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, 1);
        check("wrap_addr", bus.imem_addr, 32'h0);
        // Stall into HOLD (buffer build), then reset there
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        check("restart_addr", bus.imem_addr, 32'h4);
        // Randomized traffic against the reference model
        key = $urandom;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 3) != 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
